// File: rtl/matrix_ctrl_if.sv
// Host/RAM/multiplier/UART signal bundle for the matrix multiplier sequencer.
// master = sequencer side, slave = surrounding datapath and UART.
interface matrix_ctrl_if #(
    parameter int MAX_N      = 8,
    parameter int ELEM_BYTES = 1,
    parameter int RES_BYTES  = 2
);
    localparam int ADDR_W = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
    localparam int SEL_W  = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam int SIZE_W = 4;

    logic                    rx_valid;
    logic [7:0]              rx_data;
    logic                    tx_busy;
    logic                    mult_done;
    logic                    rx_enable;
    logic                    wr_en_a;
    logic                    wr_en_b;
    logic [ADDR_W-1:0]       wr_addr;
    logic [8*ELEM_BYTES-1:0] wr_data;
    logic                    mult_start;
    logic [ADDR_W-1:0]       res_rd_addr;
    logic [SEL_W-1:0]        res_byte_sel;
    logic                    tx_start;
    logic [SIZE_W-1:0]       matrix_size;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [1:0]              err_code;
    logic [2:0]              state;

    modport master (
        input  rx_valid, rx_data, tx_busy, mult_done,
        output rx_enable, wr_en_a, wr_en_b, wr_addr, wr_data, mult_start,
               res_rd_addr, res_byte_sel, tx_start, matrix_size, busy, done,
               err, err_code, state
    );

    modport slave (
        output rx_valid, rx_data, tx_busy, mult_done,
        input  rx_enable, wr_en_a, wr_en_b, wr_addr, wr_data, mult_start,
               res_rd_addr, res_byte_sel, tx_start, matrix_size, busy, done,
               err, err_code, state
    );
endinterface

// File: rtl/matrix_ctrl_fsm.sv
// UART-driven sequencer: frames sync/size/A/B bytes into RAM writes, launches the
// multiplier, then streams the N*N result matrix back MSB first.
module matrix_ctrl_fsm #(
    parameter int         MAX_N      = 8,
    parameter int         ELEM_BYTES = 1,
    parameter int         RES_BYTES  = 2,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         TIMEOUT    = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    matrix_ctrl_if.master bus
);
    localparam int ADDR_W = (MAX_N > 1) ? $clog2(MAX_N * MAX_N) : 1;
    localparam int SEL_W  = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;
    localparam int SIZE_W = 4;
    localparam int NN_W   = 2 * SIZE_W;
    localparam int DW     = 8 * ELEM_BYTES;
    localparam int BC_W   = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_SIZE = 3'd1,
        RX_A    = 3'd2,
        RX_B    = 3'd3,
        COMPUTE = 3'd4,
        TX      = 3'd5,
        ERROR   = 3'd6
    } state_t;

    state_t            state_q;
    logic              rx_en_q, wr_a_q, wr_b_q, mult_start_q, tx_start_q, done_q, err_q;
    logic [ADDR_W-1:0] wr_addr_q, elem_q, res_addr_q;
    logic [DW-1:0]     wr_data_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SIZE_W-1:0] size_q;
    logic [1:0]        err_code_q;
    logic [BC_W-1:0]   bcnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              pend_q, guard_q;

    logic [NN_W-1:0]   nn_last;
    logic              elem_last, byte_last, tx_last, size_ok, tmo_hit;

    assign nn_last   = NN_W'(size_q) * NN_W'(size_q) - NN_W'(1);
    assign elem_last = (NN_W'(elem_q) == nn_last);
    assign byte_last = (bcnt_q == BC_W'(ELEM_BYTES - 1));
    assign tx_last   = (NN_W'(res_addr_q) == nn_last) && (sel_q == SEL_W'(RES_BYTES - 1));
    assign size_ok   = (bus.rx_data[3:0] != 4'd0) && (bus.rx_data[3:0] <= 4'(MAX_N));
    assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_en_q      <= 1'b0;
            wr_a_q       <= 1'b0;
            wr_b_q       <= 1'b0;
            mult_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_addr_q    <= '0;
            elem_q       <= '0;
            res_addr_q   <= '0;
            wr_data_q    <= '0;
            sel_q        <= '0;
            size_q       <= '0;
            err_code_q   <= '0;
            bcnt_q       <= '0;
            tmo_q        <= '0;
            pend_q       <= 1'b0;
            guard_q      <= 1'b0;
        end else begin
            wr_a_q       <= 1'b0;
            wr_b_q       <= 1'b0;
            mult_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    rx_en_q <= 1'b1;
                    tmo_q   <= '0;
                    if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                        state_q    <= RX_SIZE;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        elem_q     <= '0;
                        bcnt_q     <= '0;
                    end
                end
                RX_SIZE: begin
                    if (bus.rx_valid) begin
                        tmo_q <= '0;
                        if (size_ok) begin
                            size_q  <= bus.rx_data[3:0];
                            state_q <= RX_A;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= 2'b01;
                            rx_en_q    <= 1'b0;
                            state_q    <= ERROR;
                        end
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        rx_en_q    <= 1'b0;
                        state_q    <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                RX_A, RX_B: begin
                    if (bus.rx_valid) begin
                        tmo_q     <= '0;
                        wr_data_q <= (wr_data_q << 8) | DW'(bus.rx_data);
                        if (byte_last) begin
                            bcnt_q    <= '0;
                            wr_addr_q <= elem_q;
                            wr_a_q    <= (state_q == RX_A);
                            wr_b_q    <= (state_q == RX_B);
                            if (elem_last) begin
                                elem_q <= '0;
                                tmo_q  <= '0;
                                if (state_q == RX_A) begin
                                    state_q <= RX_B;
                                end else begin
                                    state_q      <= COMPUTE;
                                    rx_en_q      <= 1'b0;
                                    mult_start_q <= 1'b1;
                                end
                            end else begin
                                elem_q <= elem_q + ADDR_W'(1);
                            end
                        end else begin
                            bcnt_q <= bcnt_q + BC_W'(1);
                        end
                    end else if (tmo_hit) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        rx_en_q    <= 1'b0;
                        state_q    <= ERROR;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                COMPUTE: begin
                    if (bus.mult_done) begin
                        state_q    <= TX;
                        res_addr_q <= '0;
                        sel_q      <= '0;
                        pend_q     <= 1'b0;
                        guard_q    <= 1'b0;
                    end
                end
                TX: begin
                    // tx_busy is not trusted in the request cycle or the one after it,
                    // giving the UART time to raise busy for the byte just requested.
                    if (tx_start_q) begin
                        guard_q <= 1'b1;
                    end else if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!bus.tx_busy) begin
                        if (!pend_q) begin
                            tx_start_q <= 1'b1;
                            pend_q     <= 1'b1;
                        end else if (tx_last) begin
                            pend_q  <= 1'b0;
                            done_q  <= 1'b1;
                            rx_en_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            tx_start_q <= 1'b1;
                            if (sel_q == SEL_W'(RES_BYTES - 1)) begin
                                sel_q      <= '0;
                                res_addr_q <= res_addr_q + ADDR_W'(1);
                            end else begin
                                sel_q <= sel_q + SEL_W'(1);
                            end
                        end
                    end
                end
                ERROR: begin
                    rx_en_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_enable    = rx_en_q;
    assign bus.wr_en_a      = wr_a_q;
    assign bus.wr_en_b      = wr_b_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.mult_start   = mult_start_q;
    assign bus.res_rd_addr  = res_addr_q;
    assign bus.res_byte_sel = sel_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.matrix_size  = size_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.err_code     = err_code_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_matrix_ctrl_fsm.sv
// Randomised frame-level bench for matrix_ctrl_fsm with a queue-based scoreboard
// and a simple UART busy model.
module tb_matrix_ctrl_fsm;
    localparam int MAX_N = 8;
    localparam int EB    = 2;
    localparam int RB    = 2;
    localparam int TMO   = 200;

    logic clk;
    logic rst_n;

    matrix_ctrl_if #(.MAX_N(MAX_N), .ELEM_BYTES(EB), .RES_BYTES(RB)) bus ();

    matrix_ctrl_fsm #(
        .MAX_N(MAX_N), .ELEM_BYTES(EB), .RES_BYTES(RB),
        .SYNC_BYTE(8'hA5), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct { bit is_b; int addr; int data; } wr_t;
    typedef struct { int addr; int sel; } tx_t;
    typedef struct { int code; int cyc; } er_t;

    wr_t exp_wr[$];
    tx_t exp_tx[$];
    er_t exp_er[$];
    int  exp_ms   = 0;
    int  exp_done = 0;
    int  checks   = 0;
    int  errors   = 0;
    int  cyc      = 0;
    int  busy_len = 2;
    int  t_last   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // UART model: busy rises the cycle after a request and lasts busy_len cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        wr_t w;
        tx_t t;
        er_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.wr_en_a || bus.wr_en_b) begin
                    check("wr_expected", exp_wr.size() > 0, 1);
                    if (exp_wr.size() > 0) begin
                        w = exp_wr.pop_front();
                        check("wr_en_a", bus.wr_en_a, !w.is_b);
                        check("wr_en_b", bus.wr_en_b, w.is_b);
                        check("wr_addr", bus.wr_addr, w.addr);
                        check("wr_data", bus.wr_data, w.data);
                    end
                end
                if (bus.tx_start) begin
                    check("tx_start_while_busy", bus.tx_busy, 0);
                    check("tx_expected", exp_tx.size() > 0, 1);
                    if (exp_tx.size() > 0) begin
                        t = exp_tx.pop_front();
                        check("res_rd_addr", bus.res_rd_addr, t.addr);
                        check("res_byte_sel", bus.res_byte_sel, t.sel);
                    end
                end
                if (bus.mult_start) begin
                    check("mult_start_expected", exp_ms > 0, 1);
                    if (exp_ms > 0) exp_ms--;
                end
                if (bus.done) begin
                    check("done_expected", exp_done > 0, 1);
                    check("done_after_all_bytes", exp_tx.size(), 0);
                    if (exp_done > 0) exp_done--;
                end
                if (bus.state == 3'd6) begin
                    check("error_expected", exp_er.size() > 0, 1);
                    check("error_rx_enable", bus.rx_enable, 0);
                    check("error_err", bus.err, 1);
                    if (exp_er.size() > 0) begin
                        r = exp_er.pop_front();
                        check("error_code", bus.err_code, r.code);
                        if (r.cyc >= 0) check("timeout_cycle", cyc, r.cyc);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        t_last = cyc;
    endtask

    // Reference: each element is a random value sent MSB first and expected back
    // as one write at its row-major index.
    task automatic send_matrix(input bit is_b, input int nelem);
        int v;
        for (int e = 0; e < nelem; e++) begin
            v = int'($urandom_range(0, (1 << (8 * EB)) - 1));
            exp_wr.push_back('{is_b, e, v});
            for (int k = EB - 1; k >= 0; k--) begin
                idle(int'($urandom_range(0, 3)));
                send_byte(8'((v >> (8 * k)) & 255));
            end
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.rx_enable, bus.wr_en_a, bus.wr_en_b, bus.wr_addr, bus.wr_data,
                    bus.mult_start, bus.res_rd_addr, bus.res_byte_sel, bus.tx_start,
                    bus.matrix_size, bus.busy, bus.done, bus.err, bus.err_code, bus.state});
    endfunction

    task automatic run_frame(input int n, input bit with_sync, input int blen, input int dly);
        bit got;
        int bound;
        busy_len = blen;
        exp_ms++;
        exp_done++;
        for (int e = 0; e < n * n; e++)
            for (int s = 0; s < RB; s++) exp_tx.push_back('{e, s});
        if (with_sync) send_byte(8'hA5);
        send_byte({4'($urandom_range(0, 15)), 4'(n)});
        send_matrix(1'b0, n * n);
        send_matrix(1'b1, n * n);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.mult_start) begin
                got = 1'b1;
                break;
            end
            idle(1);
        end
        check("mult_start_seen", got, 1);
        if (dly > 0) begin
            send_byte(8'($urandom_range(0, 255)));
            idle(dly - 1);
        end
        bus.mult_done = 1'b1;
        idle(1);
        bus.mult_done = 1'b0;
        got   = 1'b0;
        bound = n * n * RB * (blen + 6) + 50;
        for (int i = 0; i < bound; i++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            idle(1);
        end
        check("done_seen", got, 1);
        idle(2);
        check("idle_after_frame", bus.state, 0);
    endtask

    initial begin
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.mult_done = 1'b0;
        rst_n = 1'b0;
        idle(3);
        check("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;
        idle(3);
        check("idle_rx_enable", bus.rx_enable, 1);
        check("idle_busy", bus.busy, 0);

        // Basic 2x2 frame, mult_done in the COMPUTE entry cycle.
        run_frame(2, 1'b1, 2, 0);
        check("matrix_size", bus.matrix_size, 2);

        // Non-sync byte in IDLE is dropped.
        send_byte(8'h3C);
        idle(3);
        check("junk_dropped", bus.state, 0);

        // Slow transmitter.
        run_frame(2, 1'b1, 50, 3);

        // Bad sizes.
        exp_er.push_back('{1, -1});
        send_byte(8'hA5);
        send_byte(8'h00);
        idle(3);
        check("bad0_err", bus.err, 1);
        check("bad0_code", bus.err_code, 1);
        check("bad0_state", bus.state, 0);
        exp_er.push_back('{1, -1});
        send_byte(8'hA5);
        send_byte(8'(MAX_N + 1));
        idle(3);
        check("bad9_err", bus.err, 1);
        check("bad9_code", bus.err_code, 1);
        send_byte(8'hA5);
        check("sync_clears_err", bus.err, 0);
        check("sync_clears_code", bus.err_code, 0);
        check("sync_to_rx_size", bus.state, 1);
        run_frame(3, 1'b0, 1, 1);

        // Inter-byte timeout in RX_A.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_matrix(1'b0, 4);
        exp_er.push_back('{2, t_last + TMO});
        idle(TMO + 10);
        check("tmo_state", bus.state, 0);
        check("tmo_err", bus.err, 1);
        check("tmo_code", bus.err_code, 2);

        // Asynchronous reset in the middle of RX_B.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_matrix(1'b0, 9);
        send_matrix(1'b1, 4);
        idle(2);
        #2 rst_n = 1'b0;
        #1 check("midrx_reset_outputs", all_outputs(), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        run_frame(3, 1'b1, 2, 0);

        // Largest matrix.
        run_frame(MAX_N, 1'b1, 1, 2);

        for (int i = 0; i < 5; i++)
            run_frame(int'($urandom_range(1, MAX_N)), 1'b1,
                      int'($urandom_range(1, 4)), int'($urandom_range(0, 4)));

        idle(5);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("err_queue_drained", exp_er.size(), 0);
        check("mult_start_count", exp_ms, 0);
        check("done_count", exp_done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
